// File: rtl/pc_sequencer_if.sv
// Decode/branch-compare side to PC sequencer signal bundle.
// The slave modport is the sequencer; the master modport is the decode stage.
interface pc_sequencer_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 26,
  parameter int OFFSET_WIDTH = 16
);
  logic                    advance;
  logic [1:0]              jump_type;
  logic [INDEX_WIDTH-1:0]  instr_index;
  logic [OFFSET_WIDTH-1:0] branch_offset;
  logic [ADDR_WIDTH-1:0]   reg_target;
  logic [ADDR_WIDTH-1:0]   pc;
  logic [ADDR_WIDTH-1:0]   link_addr;
  logic                    in_delay_slot;
  logic                    misaligned_err;
  logic                    nested_err;

  modport master (
    output advance, jump_type, instr_index, branch_offset, reg_target,
    input  pc, link_addr, in_delay_slot, misaligned_err, nested_err
  );

  modport slave (
    input  advance, jump_type, instr_index, branch_offset, reg_target,
    output pc, link_addr, in_delay_slot, misaligned_err, nested_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program counter with J/JR/branch target generation and a
// one-instruction branch delay slot.
module pc_sequencer #(
  parameter int          ADDR_WIDTH   = 32,
  parameter int          INDEX_WIDTH  = 26,
  parameter int          OFFSET_WIDTH = 16,
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic         clk,
  input  logic         reset,
  pc_sequencer_if.slave bus
);
  localparam int UPPER = ADDR_WIDTH - INDEX_WIDTH - 2;

  typedef enum logic {IDLE, DELAY} state_t;
  typedef enum logic [1:0] {JT_NONE, JT_INDEX, JT_REG, JT_BRANCH} jump_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic                  mis_q, mis_d;
  logic                  nest_q, nest_d;

  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [ADDR_WIDTH-1:0] j_target;
  logic [ADDR_WIDTH-1:0] br_off;
  logic [ADDR_WIDTH-1:0] br_target;

  assign pc_plus4  = pc_q + ADDR_WIDTH'(4);
  assign br_off    = ADDR_WIDTH'($signed(bus.branch_offset));
  assign br_target = pc_plus4 + (br_off << 2);

  // J target keeps the top UPPER bits of pc+4; UPPER==0 has no region to keep.
  if (UPPER < 0) begin : g_bad_widths
    $error("pc_sequencer: ADDR_WIDTH must be at least INDEX_WIDTH+2");
  end else if (UPPER == 0) begin : g_j_noupper
    assign j_target = {bus.instr_index, 2'b00};
  end else begin : g_j_upper
    assign j_target = {pc_plus4[ADDR_WIDTH-1 -: UPPER], bus.instr_index, 2'b00};
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    mis_d    = 1'b0;
    nest_d   = 1'b0;
    if (bus.advance) begin
      if (state_q == DELAY) begin
        pc_d    = target_q;
        state_d = IDLE;
        nest_d  = (bus.jump_type != JT_NONE);
      end else begin
        pc_d = pc_plus4;
        case (jump_t'(bus.jump_type))
          JT_INDEX: begin
            target_d = j_target;
            state_d  = DELAY;
          end
          JT_BRANCH: begin
            target_d = br_target;
            state_d  = DELAY;
          end
          JT_REG: begin
            if (bus.reg_target[1:0] == 2'b00) begin
              target_d = bus.reg_target;
              state_d  = DELAY;
            end else begin
              mis_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= ADDR_WIDTH'(RESET_VECTOR);
      target_q <= '0;
      mis_q    <= 1'b0;
      nest_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      mis_q    <= mis_d;
      nest_q   <= nest_d;
    end
  end

  assign bus.pc             = pc_q;
  assign bus.link_addr      = pc_q + ADDR_WIDTH'(8);
  assign bus.in_delay_slot  = (state_q == DELAY);
  assign bus.misaligned_err = mis_q;
  assign bus.nested_err     = nest_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed plan scenarios plus random traffic,
// checked against a queue of expectations from a behavioural PC model.
module tb_pc_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  pc_sequencer_if #(.ADDR_WIDTH(32), .INDEX_WIDTH(26), .OFFSET_WIDTH(16)) bus ();

  pc_sequencer #(
    .ADDR_WIDTH(32), .INDEX_WIDTH(26), .OFFSET_WIDTH(16), .RESET_VECTOR(32'hBFC00000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] link;
    logic        dly;
    logic        mis;
    logic        nest;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_pend;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a pending-redirect flag and target replace the state machine.
  task automatic step(input bit adv, input logic [1:0] jt, input logic [25:0] idx,
                      input logic [15:0] off, input logic [31:0] rt);
    exp_t        e;
    logic [31:0] p4;
    @(negedge clk);
    bus.advance       = adv;
    bus.jump_type     = jt;
    bus.instr_index   = idx;
    bus.branch_offset = off;
    bus.reg_target    = rt;
    e.mis  = 1'b0;
    e.nest = 1'b0;
    if (adv) begin
      if (m_pend) begin
        m_pc   = m_tgt;
        m_pend = 0;
        e.nest = (jt != 2'd0);
      end else begin
        p4 = m_pc + 32'd4;
        case (jt)
          2'd1: begin
            m_tgt  = (p4 & 32'hF000_0000) | (32'(idx) * 32'd4);
            m_pend = 1;
          end
          2'd2: begin
            if (rt % 4 == 0) begin
              m_tgt  = rt;
              m_pend = 1;
            end else begin
              e.mis = 1'b1;
            end
          end
          2'd3: begin
            m_tgt  = p4 + 32'(int'($signed(off)) * 4);
            m_pend = 1;
          end
          default: ;
        endcase
        m_pc = p4;
      end
    end
    e.pc   = m_pc;
    e.link = m_pc + 32'd8;
    e.dly  = m_pend;
    q.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic model_reset();
    m_pc   = 32'hBFC00000;
    m_tgt  = '0;
    m_pend = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pc",             bus.pc,                     e.pc);
        check("link_addr",      bus.link_addr,              e.link);
        check("in_delay_slot",  32'(bus.in_delay_slot),     32'(e.dly));
        check("misaligned_err", 32'(bus.misaligned_err),    32'(e.mis));
        check("nested_err",     32'(bus.nested_err),        32'(e.nest));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin : driver
    bus.advance       = 1'b0;
    bus.jump_type     = 2'd0;
    bus.instr_index   = '0;
    bus.branch_offset = '0;
    bus.reg_target    = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_pc",   bus.pc, 32'hBFC00000);
    check("reset_dly",  32'(bus.in_delay_slot), 32'd0);
    check("reset_mis",  32'(bus.misaligned_err), 32'd0);
    check("reset_nest", 32'(bus.nested_err), 32'd0);

    repeat (3) step(1, 2'd0, '0, '0, '0);
    settle();
    check("three_adv_pc", bus.pc, 32'hBFC0000C);

    // Move to 0x10000000 via JR, then J
    step(1, 2'd2, '0, '0, 32'h10000000);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("jr_to_1000", bus.pc, 32'h10000000);
    step(1, 2'd1, 26'h3304701, '0, '0);
    settle();
    check("j_slot_pc",   bus.pc, 32'h10000004);
    check("j_slot_dly",  32'(bus.in_delay_slot), 32'd1);
    check("j_slot_link", bus.link_addr, 32'h1000000C);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("j_target",    bus.pc, 32'h1CC11C04);
    check("j_done_dly",  32'(bus.in_delay_slot), 32'd0);

    // Backward branch with stalls inside the delay window
    step(1, 2'd2, '0, '0, 32'h00000100);
    step(1, 2'd0, '0, '0, '0);
    step(1, 2'd3, '0, 16'hFFFC, '0);
    settle();
    check("br_slot_pc", bus.pc, 32'h00000104);
    repeat (3) step(0, 2'd0, '0, '0, '0);
    settle();
    check("br_stall_pc", bus.pc, 32'h00000104);
    check("br_stall_dly", 32'(bus.in_delay_slot), 32'd1);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("br_target", bus.pc, 32'h000000F4);

    // Misaligned JR then aligned JR
    step(1, 2'd2, '0, '0, 32'h00400002);
    settle();
    check("mis_pulse", 32'(bus.misaligned_err), 32'd1);
    check("mis_pc",    bus.pc, 32'h000000F8);
    check("mis_dly",   32'(bus.in_delay_slot), 32'd0);
    step(0, 2'd0, '0, '0, '0);
    settle();
    check("mis_clear", 32'(bus.misaligned_err), 32'd0);
    step(1, 2'd2, '0, '0, 32'h00400000);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("jr_target", bus.pc, 32'h00400000);

    // Nested jump in the delay slot is ignored
    step(1, 2'd1, 26'd5, '0, '0);
    step(1, 2'd1, 26'd7, '0, '0);
    settle();
    check("nest_pulse", 32'(bus.nested_err), 32'd1);
    check("nest_pc",    bus.pc, 32'h00000014);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("nest_clear", 32'(bus.nested_err), 32'd0);

    // PC increment and link address wrap
    step(1, 2'd2, '0, '0, 32'hFFFFFFFC);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("wrap_link", bus.link_addr, 32'h00000004);
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("wrap_pc", bus.pc, 32'h00000000);

    // Asynchronous reset while in the delay slot
    step(1, 2'd1, 26'h100, '0, '0);
    settle();
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    check("areset_pc",  bus.pc, 32'hBFC00000);
    check("areset_dly", 32'(bus.in_delay_slot), 32'd0);
    @(negedge clk);
    bus.advance = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(1, 2'd0, '0, '0, '0);
    settle();
    check("areset_no_stale", bus.pc, 32'hBFC00004);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rt;
      rt = $urandom;
      if ($urandom_range(0, 1) == 0) rt[1:0] = 2'b00;
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 26'($urandom),
           16'($urandom), rt);
    end

    settle();
    settle();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
